mux4a1_rr_sched: RTL and testbench
==================================

Name: mux4a1_rr_sched

Overview:
- Round-robin scheduler that shares the single serialized output of the 4-lane byte mux between four lanes.
- Each lane has a private DEPTH-entry FIFO. A registered arbiter drains the FIFOs onto one output stream with ready/valid backpressure.
- Sits in the fast clk_4f domain, between the lane sources and the downstream serial consumer.
- Reports per-lane full and sticky overflow status.

Parameters:
- DATA_W, 8, width of each lane byte.
- DEPTH, 4, entries per lane FIFO; must be a power of two and at least 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk_4f  in  1  single clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- valid0..valid3  in  1 each  lane write strobe.
- data_in0_mux..data_in3_mux  in  DATA_W each  lane data.
- out_ready  in  1  downstream accepts dataout_mux this cycle.
- validout  out  1  dataout_mux holds a valid byte.
- dataout_mux  out  DATA_W  scheduled byte.
- lane_out  out  2  source lane of dataout_mux.
- full  out  4  bit i set when FIFO i count equals DEPTH.
- overflow  out  4  bit i is sticky: a write to lane i was dropped.

Behaviour:
- Reset, sampled at a rising edge with reset=1:
  - All FIFO counts and pointers = 0.
  - validout=0, dataout_mux=0, lane_out=0, full=0, overflow=0.
  - Round-robin pointer last_grant=3, so lane 0 has first priority.
  - Reset mid-operation discards all buffered and in-flight data; no partial output.
- Push:
  - Lane i writes data_in_i at the edge when valid_i=1 and count_i<DEPTH, using the count before this edge.
  - If valid_i=1 and count_i==DEPTH, the byte is dropped and overflow[i] is set. This holds even if lane i is popped in the same cycle; full is judged on the pre-edge count.
- Load condition: load = (validout==0) || (out_ready==1).
- Arbitration (combinational, each cycle):
  - Eligible lanes are those with pre-edge count_i>0.
  - Search order is last_grant+1, +2, +3, +4, mod 4; the first eligible lane wins.
- Pop / output register, on load:
  - If a winner exists, pop the head of the winner's FIFO into dataout_mux.
  - Set lane_out=winner, validout=1, last_grant=winner.
  - If no lane is eligible, validout=0, and dataout_mux and lane_out hold their values.
- When load=0 (validout=1 and out_ready=0): dataout_mux, lane_out and validout hold stable; no pop; last_grant unchanged.
- Latency:
  - A byte pushed at edge k into an empty system with out_ready=1 appears on dataout_mux after edge k+1.
  - A byte pushed into an empty FIFO is not eligible in the same cycle, so there is no same-cycle bypass.
- Simultaneous push and pop on one lane: both occur; the count is unchanged. The pop returns the old head; the new byte goes to the tail.
- Pointers wrap modulo DEPTH. Count is PTR_W+1 bits, range 0..DEPTH.
- full[i] is combinational from the registered count.
- overflow clears only on reset.
- Throughput: with out_ready held high, one byte per clk_4f cycle is sustained while any lane is non-empty.
- Fairness: with all four lanes continuously non-empty, the grant sequence is strictly 0,1,2,3,0,…

Test Plan:
- Reset, then drive valid0..3=1 for one cycle with data 0xA0, 0xB1, 0xC2, 0xD3, and out_ready=1 -> outputs on consecutive cycles are 0xA0/lane0, 0xB1/lane1, 0xC2/lane2, 0xD3/lane3, then validout=0.
- Only lane 2 writes 0x11, 0x22, 0x33 on back-to-back cycles -> dataout_mux is 0x11, 0x22, 0x33, each 1 cycle after its write edge, with lane_out=2.
- out_ready=0, then write lanes 0 and 1 -> validout=1, and dataout_mux is held at lane 0's byte for 5 stall cycles. Raising out_ready yields the lane 1 byte on the next cycle.
- out_ready=0, then write 6 bytes to lane 3 -> full[3]=1 after 4 accepted writes (one already sits in the output register). overflow[3]=1 after the next drop. On drain, exactly the first DEPTH+1 bytes are output in order.
- Lane 1 full with a simultaneous valid1 and pop -> the write is dropped and overflow[1]=1. With count 2 and a simultaneous push and pop, the count stays 2 and the data order is preserved.
- Assert reset for 1 cycle with 3 lanes non-empty -> next cycle validout=0, full=0, overflow=0. The first grant after reset is the lowest eligible lane starting from lane 0.

Source files
------------

// File: rtl/mux4a1_rr_sched.sv
// Round-robin scheduler draining four per-lane byte FIFOs onto one
// ready/valid output stream, with per-lane full and sticky overflow status.
module mux4a1_rr_sched #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic              valid0,
  input  logic              valid1,
  input  logic              valid2,
  input  logic              valid3,
  input  logic [DATA_W-1:0] data_in0_mux,
  input  logic [DATA_W-1:0] data_in1_mux,
  input  logic [DATA_W-1:0] data_in2_mux,
  input  logic [DATA_W-1:0] data_in3_mux,
  input  logic              out_ready,
  output logic              validout,
  output logic [DATA_W-1:0] dataout_mux,
  output logic [1:0]        lane_out,
  output logic [3:0]        full,
  output logic [3:0]        overflow
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q    [4][DEPTH];
  logic [DATA_W-1:0] mem_d    [4][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [4];
  logic [PTR_W-1:0]  wr_ptr_d [4];
  logic [PTR_W-1:0]  rd_ptr_q [4];
  logic [PTR_W-1:0]  rd_ptr_d [4];
  logic [PTR_W:0]    count_q  [4];
  logic [PTR_W:0]    count_d  [4];
  logic [3:0]        ovf_q, ovf_d;
  logic              vld_q, vld_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [1:0]        lane_q, lane_d;
  logic [1:0]        last_q, last_d;

  logic [3:0]        vin;
  logic [DATA_W-1:0] din [4];
  logic              load;
  logic              have_win;
  logic [1:0]        win;
  logic [1:0]        cand;
  logic [3:0]        push, pop;

  assign vin    = {valid3, valid2, valid1, valid0};
  assign din[0] = data_in0_mux;
  assign din[1] = data_in1_mux;
  assign din[2] = data_in2_mux;
  assign din[3] = data_in3_mux;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    vld_d    = vld_q;
    dout_d   = dout_q;
    lane_d   = lane_q;
    last_d   = last_q;
    push     = '0;
    pop      = '0;
    have_win = 1'b0;
    win      = 2'd0;
    cand     = 2'd0;

    load = !vld_q || out_ready;

    // Search starts one past the last grant; k=4 wraps back to last_q itself.
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!have_win && count_q[cand] != '0) begin
        have_win = 1'b1;
        win      = cand;
      end
    end

    for (int i = 0; i < 4; i++) begin
      pop[i]  = load && have_win && (win == 2'(i));
      push[i] = vin[i] && (count_q[i] != DEPTH_C);
      if (vin[i] && count_q[i] == DEPTH_C) ovf_d[i] = 1'b1;
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i]] = din[i];
        wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
      end
      if (pop[i]) rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
      case ({push[i], pop[i]})
        2'b10:   count_d[i] = count_q[i] + (PTR_W+1)'(1);
        2'b01:   count_d[i] = count_q[i] - (PTR_W+1)'(1);
        default: count_d[i] = count_q[i];
      endcase
    end

    if (load) begin
      if (have_win) begin
        dout_d = mem_q[win][rd_ptr_q[win]];
        lane_d = win;
        vld_d  = 1'b1;
        last_d = win;
      end else begin
        vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      ovf_q  <= '0;
      vld_q  <= 1'b0;
      dout_q <= '0;
      lane_q <= 2'd0;
      last_q <= 2'd3;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      vld_q    <= vld_d;
      dout_q   <= dout_d;
      lane_q   <= lane_d;
      last_q   <= last_d;
    end
  end

  // Storage needs no reset: counts and pointers gate every read.
  always_ff @(posedge clk_4f) begin
    mem_q <= mem_d;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) full[i] = (count_q[i] == DEPTH_C);
  end

  assign validout    = vld_q;
  assign dataout_mux = dout_q;
  assign lane_out    = lane_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_mux4a1_rr_sched.sv
// Bench for mux4a1_rr_sched: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mux4a1_rr_sched;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int PTR_W  = 2;

  logic              clk_4f;
  logic              rst;
  logic [3:0]        vld;
  logic [DATA_W-1:0] din [4];
  logic              out_ready;
  logic              validout;
  logic [DATA_W-1:0] dataout_mux;
  logic [1:0]        lane_out;
  logic [3:0]        full;
  logic [3:0]        overflow;

  mux4a1_rr_sched #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk_4f       (clk_4f),
    .reset        (rst),
    .valid0       (vld[0]),
    .valid1       (vld[1]),
    .valid2       (vld[2]),
    .valid3       (vld[3]),
    .data_in0_mux (din[0]),
    .data_in1_mux (din[1]),
    .data_in2_mux (din[2]),
    .data_in3_mux (din[3]),
    .out_ready    (out_ready),
    .validout     (validout),
    .dataout_mux  (dataout_mux),
    .lane_out     (lane_out),
    .full         (full),
    .overflow     (overflow)
  );

  initial clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DATA_W-1:0] mq [4][$];
  logic              m_vld;
  logic [DATA_W-1:0] m_dat;
  logic [1:0]        m_lane;
  logic [3:0]        m_ovf;
  int                m_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int  cnt [4];
    bit  hw;
    int  w;
    int  l;
    if (rst) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
      m_vld  = 1'b0;
      m_dat  = '0;
      m_lane = 2'd0;
      m_ovf  = '0;
      m_last = 3;
      return;
    end
    for (int i = 0; i < 4; i++) cnt[i] = mq[i].size();
    hw = 0;
    w  = 0;
    for (int k = 1; k <= 4; k++) begin
      l = (m_last + k) % 4;
      if (!hw && cnt[l] > 0) begin
        hw = 1;
        w  = l;
      end
    end
    if (!m_vld || out_ready) begin
      if (hw) begin
        m_dat  = mq[w].pop_front();
        m_lane = 2'(w);
        m_vld  = 1'b1;
        m_last = w;
      end else begin
        m_vld = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (vld[i]) begin
        if (cnt[i] < DEPTH) mq[i].push_back(din[i]);
        else m_ovf[i] = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    logic [3:0] efull;
    for (int i = 0; i < 4; i++) efull[i] = (mq[i].size() == DEPTH);
    chk("validout", 32'(validout), 32'(m_vld));
    chk("dataout_mux", 32'(dataout_mux), 32'(m_dat));
    chk("lane_out", 32'(lane_out), 32'(m_lane));
    chk("full", 32'(full), 32'(efull));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_4f);
    #1;
    compare_all();
  endtask

  // Literal expectations checked against both the DUT and the model.
  task automatic expect_out(input string name, input logic v, input logic [7:0] d, input logic [1:0] l);
    chk({name, "_valid"}, 32'(validout), 32'(v));
    chk({name, "_model_valid"}, 32'(m_vld), 32'(v));
    if (v) begin
      chk({name, "_data"}, 32'(dataout_mux), 32'(d));
      chk({name, "_lane"}, 32'(lane_out), 32'(l));
      chk({name, "_model_data"}, 32'(m_dat), 32'(d));
    end
  endtask

  task automatic idle();
    vld = 4'b0000;
    for (int i = 0; i < 4; i++) din[i] = '0;
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    idle();
    m_last = 3;
    m_vld  = 1'b0;
    m_dat  = '0;
    m_lane = '0;
    m_ovf  = '0;

    // Reset state
    tick();
    tick();
    expect_out("reset", 1'b0, 8'h00, 2'd0);
    chk("reset_full", 32'(full), 32'h0);
    chk("reset_ovf", 32'(overflow), 32'h0);
    rst = 1'b0;

    // All four lanes in one cycle
    vld = 4'b1111;
    din[0] = 8'hA0; din[1] = 8'hB1; din[2] = 8'hC2; din[3] = 8'hD3;
    tick();
    expect_out("t1_push", 1'b0, 8'h00, 2'd0);
    idle();
    tick(); expect_out("t1_a", 1'b1, 8'hA0, 2'd0);
    tick(); expect_out("t1_b", 1'b1, 8'hB1, 2'd1);
    tick(); expect_out("t1_c", 1'b1, 8'hC2, 2'd2);
    tick(); expect_out("t1_d", 1'b1, 8'hD3, 2'd3);
    tick(); expect_out("t1_end", 1'b0, 8'h00, 2'd0);

    // Lane 2 back-to-back, one cycle latency
    vld = 4'b0100; din[2] = 8'h11; tick();
    expect_out("t2_lat", 1'b0, 8'h00, 2'd0);
    din[2] = 8'h22; tick(); expect_out("t2_11", 1'b1, 8'h11, 2'd2);
    din[2] = 8'h33; tick(); expect_out("t2_22", 1'b1, 8'h22, 2'd2);
    idle();         tick(); expect_out("t2_33", 1'b1, 8'h33, 2'd2);
    tick(); expect_out("t2_end", 1'b0, 8'h00, 2'd0);

    // Stall with lanes 0 and 1 queued
    out_ready = 1'b0;
    vld = 4'b0011; din[0] = 8'h40; din[1] = 8'h51;
    tick();
    idle();
    tick(); expect_out("t3_load", 1'b1, 8'h40, 2'd0);
    for (int s = 0; s < 5; s++) begin
      tick(); expect_out("t3_stall", 1'b1, 8'h40, 2'd0);
    end
    out_ready = 1'b1;
    tick(); expect_out("t3_l1", 1'b1, 8'h51, 2'd1);
    tick(); expect_out("t3_end", 1'b0, 8'h00, 2'd0);

    // Lane 3 fill and overflow while stalled
    out_ready = 1'b0;
    vld = 4'b1000;
    for (int b = 0; b < 6; b++) begin
      din[3] = 8'(8'h60 + b);
      tick();
      if (b == 4) begin
        chk("t4_full", 32'(full), 32'h8);
        chk("t4_noovf", 32'(overflow), 32'h0);
      end
    end
    chk("t4_ovf", 32'(overflow), 32'h8);
    expect_out("t4_head", 1'b1, 8'h60, 2'd3);
    idle();
    out_ready = 1'b1;
    for (int b = 1; b < 5; b++) begin
      tick(); expect_out("t4_drain", 1'b1, 8'(8'h60 + b), 2'd3);
    end
    tick(); expect_out("t4_end", 1'b0, 8'h00, 2'd0);

    // Lane 1 full with simultaneous push and pop
    out_ready = 1'b0;
    vld = 4'b0010;
    for (int b = 0; b < 5; b++) begin
      din[1] = 8'(8'h70 + b);
      tick();
    end
    chk("t5_full", 32'(full), 32'h2);
    out_ready = 1'b1;
    din[1] = 8'h7F;
    tick();
    expect_out("t5_pop", 1'b1, 8'h71, 2'd1);
    chk("t5_ovf", 32'(overflow), 32'hA);
    chk("t5_notfull", 32'(full), 32'h0);
    idle();
    for (int b = 2; b < 5; b++) begin
      tick(); expect_out("t5_drain", 1'b1, 8'(8'h70 + b), 2'd1);
    end
    tick(); expect_out("t5_end", 1'b0, 8'h00, 2'd0);

    // Count 2 with simultaneous push and pop
    out_ready = 1'b0;
    vld = 4'b0010;
    din[1] = 8'h81; tick();
    din[1] = 8'h82; tick(); expect_out("t5b_81", 1'b1, 8'h81, 2'd1);
    din[1] = 8'h83; tick();
    out_ready = 1'b1;
    din[1] = 8'h84; tick(); expect_out("t5b_82", 1'b1, 8'h82, 2'd1);
    idle();
    tick(); expect_out("t5b_83", 1'b1, 8'h83, 2'd1);
    tick(); expect_out("t5b_84", 1'b1, 8'h84, 2'd1);
    tick(); expect_out("t5b_end", 1'b0, 8'h00, 2'd0);

    // Reset mid-operation
    out_ready = 1'b0;
    vld = 4'b1101; din[0] = 8'hE0; din[2] = 8'hE2; din[3] = 8'hE3;
    tick(); tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_out("t6_rst", 1'b0, 8'h00, 2'd0);
    chk("t6_full", 32'(full), 32'h0);
    chk("t6_ovf", 32'(overflow), 32'h0);
    out_ready = 1'b1;
    vld = 4'b1010; din[1] = 8'h91; din[3] = 8'h93;
    tick();
    idle();
    tick(); expect_out("t6_first", 1'b1, 8'h91, 2'd1);
    tick(); expect_out("t6_second", 1'b1, 8'h93, 2'd3);
    tick(); expect_out("t6_end", 1'b0, 8'h00, 2'd0);

    // Randomized traffic with varying backpressure and rare resets
    for (int blk = 0; blk < 20; blk++) begin
      int rdy_pct;
      int vld_pct;
      rdy_pct = $urandom_range(10, 100);
      vld_pct = $urandom_range(5, 60);
      for (int c = 0; c < 200; c++) begin
        rst = ($urandom_range(0, 399) == 0);
        out_ready = ($urandom_range(0, 99) < rdy_pct);
        for (int i = 0; i < 4; i++) begin
          vld[i] = ($urandom_range(0, 99) < vld_pct);
          din[i] = 8'($urandom);
        end
        tick();
      end
    end
    rst = 1'b0;
    idle();
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
